// File: rtl/inner_bell_pkg.sv
// Shared definitions for the card/bell game blocks.
//   - state_t      : dealer FSM states
//   - widths       : card colour, card number and reaction-score widths
//   - NUM_NONE     : number shown when no card is on the table
//   - NUM_MAX      : highest card number
//   - KEY_P1/P2    : player key codes, decoded upstream into `bell`
//   - LFSR_TAPS    : Galois mask for x^16+x^14+x^13+x^11+1
//   - card_number  : maps three random bits onto a card number 1..NUM_MAX
package inner_bell_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int COLOR_W = 2;
  localparam int NUM_W   = 3;
  localparam int SCORE_W = 8;
  localparam int LFSR_W  = 16;

  localparam logic [NUM_W-1:0] NUM_NONE = 3'd0;
  localparam logic [NUM_W-1:0] NUM_MAX  = 3'd5;

  localparam logic [3:0] KEY_P1 = 4'b0111;
  localparam logic [3:0] KEY_P2 = 4'b1001;

  // Right-shifting Galois form: bits 15,13,12,10 are toggled when the
  // bit shifted out is 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // (r mod 5) + 1 for a 3-bit r, done with a compare instead of a divider:
  // 0..4 map to 1..5, and 5..7 wrap around to 1..3.
  function automatic logic [NUM_W-1:0] card_number(input logic [2:0] r);
    if (r >= NUM_MAX) begin
      return r - (NUM_MAX - 3'd1);
    end else begin
      return r + 3'd1;
    end
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit Galois LFSR used as the dealer's card source.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset, loads SEED
//   lfsr  out  current 16-bit register state
// Parameter SEED must be non-zero or the register locks up at zero.
// The register advances every cycle out of reset.
module card_lfsr
  import inner_bell_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Card dealer: producer side of the card/bell interface.
// Flips cards alternately to player A and player B every FLIP_CYCLES,
// reloads the reaction score `count` at each flip and counts it down,
// freezes the table when the bell rings, clears it when scoring is done,
// and stops once DECK_SIZE cards have been dealt.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   start      in   pulse: begin a game from IDLE or OVER
//   bell       in   pulse: a player key was pressed
//   resume     in   pulse: scoring of the held round is complete
//   c1, n1     out  player A face card (colour, number; number 0 = none)
//   c2, n2     out  player B face card (colour, number; number 0 = none)
//   count      out  current reaction score
//   turn       out  player of the last flip (0 = A, 1 = B)
//   hold       out  table frozen awaiting resume
//   dealt      out  cards dealt so far
//   game_over  out  deck exhausted
//   state_dbg  out  FSM state (state_t encoding) for observation
// Pulse inputs are sampled level-per-cycle; callers give single-cycle pulses.
module card_dealer
  import inner_bell_pkg::*;
#(
  parameter int                 FLIP_CYCLES = 1000,
  parameter int                 COUNT_DIV   = 100,
  parameter logic [SCORE_W-1:0] COUNT_INIT  = 8'd100,
  parameter int                 DECK_SIZE   = 56,
  parameter logic [LFSR_W-1:0]  SEED        = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               bell,
  input  logic               resume,
  output logic [COLOR_W-1:0] c1,
  output logic [NUM_W-1:0]   n1,
  output logic [COLOR_W-1:0] c2,
  output logic [NUM_W-1:0]   n2,
  output logic [SCORE_W-1:0] count,
  output logic               turn,
  output logic               hold,
  output logic [7:0]         dealt,
  output logic               game_over,
  output logic [1:0]         state_dbg
);

  localparam int FT_W = (FLIP_CYCLES > 2) ? $clog2(FLIP_CYCLES) : 1;
  localparam int DT_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  localparam logic [FT_W-1:0] FLIP_LAST = FT_W'(FLIP_CYCLES - 1);
  localparam logic [DT_W-1:0] DIV_LAST  = DT_W'(COUNT_DIV - 1);
  localparam logic [7:0]      DECK_N    = 8'(DECK_SIZE);

  state_t              state, state_n;
  logic [COLOR_W-1:0]  c1_n, c2_n;
  logic [NUM_W-1:0]    n1_n, n2_n;
  logic [SCORE_W-1:0]  count_n;
  logic                turn_n;
  logic [7:0]          dealt_n;
  logic [FT_W-1:0]     flip_tmr, flip_tmr_n;
  logic [DT_W-1:0]     div_tmr, div_tmr_n;
  logic                do_flip;
  logic [LFSR_W-1:0]   lfsr;
  logic                unused_lfsr_bits;

  card_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  // Only the low five bits feed a card.
  assign unused_lfsr_bits = ^lfsr[LFSR_W-1:5];

  assign hold      = (state == HOLD);
  assign game_over = (state == OVER);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      c1       <= '0;
      n1       <= NUM_NONE;
      c2       <= '0;
      n2       <= NUM_NONE;
      count    <= '0;
      turn     <= 1'b1;
      dealt    <= '0;
      flip_tmr <= '0;
      div_tmr  <= '0;
    end else begin
      state    <= state_n;
      c1       <= c1_n;
      n1       <= n1_n;
      c2       <= c2_n;
      n2       <= n2_n;
      count    <= count_n;
      turn     <= turn_n;
      dealt    <= dealt_n;
      flip_tmr <= flip_tmr_n;
      div_tmr  <= div_tmr_n;
    end
  end

  always_comb begin
    state_n    = state;
    c1_n       = c1;
    n1_n       = n1;
    c2_n       = c2;
    n2_n       = n2;
    count_n    = count;
    turn_n     = turn;
    dealt_n    = dealt;
    flip_tmr_n = flip_tmr;
    div_tmr_n  = div_tmr;
    do_flip    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          do_flip = 1'b1;
          state_n = RUN;
        end
      end

      RUN: begin
        // Bell beats a simultaneous flip expiry; timers and count freeze.
        if (bell) begin
          state_n = HOLD;
        end else if (flip_tmr == FLIP_LAST) begin
          if (dealt == DECK_N) begin
            state_n = OVER;
          end else begin
            do_flip = 1'b1;
          end
        end else begin
          flip_tmr_n = flip_tmr + FT_W'(1);
          if (div_tmr == DIV_LAST) begin
            div_tmr_n = '0;
            // Never reaches 0 while a card is showing.
            count_n   = (count > 8'd1) ? count - 8'd1 : 8'd1;
          end else begin
            div_tmr_n = div_tmr + DT_W'(1);
          end
        end
      end

      HOLD: begin
        // count keeps its frozen value until the next flip reloads it.
        if (resume) begin
          c1_n       = '0;
          n1_n       = NUM_NONE;
          c2_n       = '0;
          n2_n       = NUM_NONE;
          flip_tmr_n = '0;
          div_tmr_n  = '0;
          state_n    = (dealt < DECK_N) ? RUN : OVER;
        end
      end

      OVER: begin
        // Same clear as reset (LFSR excepted), then the opening flip to A.
        if (start) begin
          c1_n    = '0;
          n1_n    = NUM_NONE;
          c2_n    = '0;
          n2_n    = NUM_NONE;
          turn_n  = 1'b1;
          dealt_n = '0;
          do_flip = 1'b1;
          state_n = RUN;
        end
      end

      default: state_n = IDLE;
    endcase

    // Flip: the new turn's card comes from the LFSR, the other card stays.
    if (do_flip) begin
      turn_n = ~turn_n;
      if (turn_n == 1'b0) begin
        c1_n = lfsr[1:0];
        n1_n = card_number(lfsr[4:2]);
      end else begin
        c2_n = lfsr[1:0];
        n2_n = card_number(lfsr[4:2]);
      end
      count_n    = COUNT_INIT;
      dealt_n    = dealt_n + 8'd1;
      flip_tmr_n = '0;
      div_tmr_n  = '0;
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: a short-period dealer checked every cycle against
// a behavioural model, plus a long-period dealer for the countdown floor.
module tb_card_dealer;
  import inner_bell_pkg::*;

  localparam int          FLIP      = 4;
  localparam int          DIV       = 2;
  localparam int          INIT      = 10;
  localparam int          DECK      = 6;
  localparam int          LONG_FLIP = 40;
  localparam logic [15:0] SEED      = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, bell, resume, start_l;
  logic [1:0] c1, c2, c1_l, c2_l;
  logic [2:0] n1, n2, n1_l, n2_l;
  logic [7:0] count, count_l, dealt, dealt_l;
  logic       turn, hold, game_over, turn_l, hold_l, game_over_l;
  logic [1:0] state_dbg, state_dbg_l;

  card_dealer #(
    .FLIP_CYCLES (FLIP), .COUNT_DIV (DIV), .COUNT_INIT (8'(INIT)),
    .DECK_SIZE (DECK), .SEED (SEED)
  ) u_dut (
    .clk (clk), .rst (rst), .start (start), .bell (bell), .resume (resume),
    .c1 (c1), .n1 (n1), .c2 (c2), .n2 (n2), .count (count), .turn (turn),
    .hold (hold), .dealt (dealt), .game_over (game_over), .state_dbg (state_dbg)
  );

  card_dealer #(
    .FLIP_CYCLES (LONG_FLIP), .COUNT_DIV (DIV), .COUNT_INIT (8'(INIT)),
    .DECK_SIZE (DECK), .SEED (SEED)
  ) u_dut_long (
    .clk (clk), .rst (rst), .start (start_l), .bell (1'b0), .resume (1'b0),
    .c1 (c1_l), .n1 (n1_l), .c2 (c2_l), .n2 (n2_l), .count (count_l), .turn (turn_l),
    .hold (hold_l), .dealt (dealt_l), .game_over (game_over_l), .state_dbg (state_dbg_l)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Table contents and game phase; the score is derived arithmetically from
  // the value it started at and the running cycles elapsed since then.
  state_t      m_state;
  logic [15:0] m_lfsr;
  int m_c1, m_n1, m_c2, m_n2, m_turn, m_dealt, m_base, m_elapsed;

  function automatic int exp_count();
    int v;
    if (m_state == IDLE) return 0;
    v = m_base - m_elapsed / DIV;
    return (v < 1) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_state = IDLE; m_lfsr = SEED;
    m_c1 = 0; m_n1 = 0; m_c2 = 0; m_n2 = 0;
    m_turn = 1; m_dealt = 0; m_base = 0; m_elapsed = 0;
  endtask

  task automatic model_clear_cards();
    m_c1 = 0; m_n1 = 0; m_c2 = 0; m_n2 = 0;
  endtask

  task automatic model_deal(input logic [15:0] r);
    int col, num;
    col = int'(r) % 4;
    num = ((int'(r) / 4) % 8) % 5 + 1;
    m_turn = 1 - m_turn;
    if (m_turn == 0) begin m_c1 = col; m_n1 = num; end
    else             begin m_c2 = col; m_n2 = num; end
    m_base = INIT; m_elapsed = 0; m_dealt++;
  endtask

  task automatic model_step(input bit s, input bit b, input bit r);
    logic [15:0] cur;
    cur = m_lfsr;
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    case (m_state)
      IDLE: if (s) begin model_deal(cur); m_state = RUN; end
      RUN: begin
        if (b) m_state = HOLD;
        else if (m_elapsed + 1 == FLIP) begin
          if (m_dealt == DECK) m_state = OVER;
          else model_deal(cur);
        end else m_elapsed++;
      end
      HOLD: if (r) begin
        m_base = exp_count(); m_elapsed = 0;
        model_clear_cards();
        m_state = (m_dealt < DECK) ? RUN : OVER;
      end
      OVER: if (s) begin
        model_clear_cards(); m_turn = 1; m_dealt = 0;
        model_deal(cur); m_state = RUN;
      end
      default: m_state = IDLE;
    endcase
  endtask

  task automatic check_outputs();
    check_eq("c1", c1, m_c1);
    check_eq("n1", n1, m_n1);
    check_eq("c2", c2, m_c2);
    check_eq("n2", n2, m_n2);
    check_eq("count", count, exp_count());
    check_eq("turn", turn, m_turn);
    check_eq("dealt", dealt, m_dealt);
    check_eq("hold", hold, m_state == HOLD);
    check_eq("game_over", game_over, m_state == OVER);
    check_eq("state", state_dbg, m_state);
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after an edge; outputs are checked there too.
  task automatic cycle(input bit s, input bit b, input bit r);
    start = s; bell = b; resume = r;
    @(posedge clk);
    model_step(s, b, r);
    #1;
    start = 1'b0; bell = 1'b0; resume = 1'b0; start_l = 1'b0;
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ps, pb, pr, s, b, r;

    rst = 1'b0; start = 1'b0; bell = 1'b0; resume = 1'b0; start_l = 1'b0;
    model_reset();
    #12;
    check_outputs();
    check_eq("long_rst_count", count_l, 0);
    rst = 1'b1;

    // Long dealer opens while the short one sits idle with no start.
    start_l = 1'b1;
    cycle(0, 0, 0);
    for (int k = 0; k < LONG_FLIP; k++)
      exp_q.push_back(8'((INIT - k / DIV < 1) ? 1 : INIT - k / DIV));
    for (int k = 0; k < LONG_FLIP; k++) begin
      check_eq("long_count", count_l, exp_q.pop_front());
      cycle(0, 0, 0);
    end
    check_eq("long_reflip_count", count_l, INIT);
    check_eq("long_reflip_dealt", dealt_l, 2);
    check_eq("idle_no_flip", dealt, 0);

    // First flip goes to A.
    cycle(1, 0, 0);
    check_eq("first_turn", turn, 0);
    check_eq("n1_range", (n1 >= 3'd1 && n1 <= 3'd5), 1);
    check_eq("first_count", count, INIT);
    repeat (3) cycle(0, 0, 0);

    // Bell on the cycle the flip timer expires: hold wins.
    cycle(0, 1, 0);
    check_eq("bell_hold", hold, 1);
    check_eq("bell_no_flip", dealt, 1);
    repeat (10) cycle(0, 0, 0);
    check_eq("frozen_count", count, INIT - (FLIP - 1) / DIV);
    cycle(0, 0, 1);
    check_eq("resume_n1", n1, 0);
    repeat (FLIP) cycle(0, 0, 0);
    check_eq("after_resume_turn", turn, 1);
    check_eq("after_resume_dealt", dealt, 2);

    // Run out the deck.
    for (int i = 0; i < 80 && m_state != OVER; i++) cycle(0, 0, 0);
    check_eq("over_state", state_dbg, OVER);
    check_eq("over_dealt", dealt, DECK);
    repeat (FLIP + 2) cycle(0, 0, 0);
    check_eq("no_extra_card", dealt, DECK);
    cycle(0, 1, 0);
    check_eq("over_bell_ignored", hold, 0);
    cycle(1, 0, 0);
    check_eq("restart_dealt", dealt, 1);

    // Random pulses, kept to single cycles.
    ps = 0; pb = 0; pr = 0;
    repeat (600) begin
      s = !ps && ($urandom_range(0, 19) == 0);
      b = !pb && ($urandom_range(0, 7) == 0);
      r = !pr && ($urandom_range(0, 5) == 0);
      cycle(s, b, r);
      ps = s; pb = b; pr = r;
    end

    // Asynchronous reset while holding.
    for (int i = 0; i < 30 && m_state != HOLD; i++)
      cycle(m_state == IDLE || m_state == OVER, m_state == RUN, 0);
    check_eq("reach_hold", hold, 1);
    #2 rst = 1'b0;
    model_reset();
    #1 check_outputs();
    #2 rst = 1'b1;
    cycle(0, 0, 1);
    check_eq("resume_after_rst", state_dbg, IDLE);
    repeat (5) cycle(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Producer side of the card/bell interface: generates face-up cards (c1,n1 for player A; c2,n2 for player B) and the reaction-score value `count`.
- These outputs feed the bell-check, score-control and winner logic.
- Flips cards alternately A/B at a fixed period and freezes the table when the bell is rung.
- Clears the table once the round has been scored, and ends the game when the deck is exhausted.

Parameters:
- FLIP_CYCLES, 1000, clock cycles between successive flips (>=2).
- COUNT_DIV, 100, cycles per decrement of `count` (>=1).
- COUNT_INIT, 8'd100, value loaded into `count` at every flip (>=1).
- DECK_SIZE, 56, total cards dealt before game over (1..255).
- SEED, 16'hACE1, LFSR reset value (must be non-zero).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a game from IDLE or OVER
- bell  in  1  pulse; a player key (7 or 9) was pressed
- resume  in  1  pulse; scoring of the held round has completed
- c1  out  2  player A face-card colour
- n1  out  3  player A face-card number, 0 = no card
- c2  out  2  player B face-card colour
- n2  out  3  player B face-card number, 0 = no card
- count  out  8  current reaction score, unsigned
- turn  out  1  player of the last flip (0 = A, 1 = B)
- hold  out  1  table frozen awaiting resume
- dealt  out  8  cards dealt so far
- game_over  out  1  deck exhausted

Behaviour:
- Reset (asynchronous, rst=0) forces the following; the LFSR is reset to SEED.
  - state=IDLE
  - c1=c2=0, n1=n2=0, count=0, turn=1, hold=0, dealt=0, game_over=0
  - flip timer and divide timer = 0
- States: IDLE, RUN, HOLD, OVER.
- IDLE:
  - outputs hold their reset values.
  - start -> first flip on the next edge (player A), state RUN.
- Flip action (single edge):
  - turn toggles; the new turn's card is loaded from the LFSR.
    - colour = lfsr[1:0]
    - number = (lfsr[4:2] mod 5) + 1, giving range 1..5
  - count <= COUNT_INIT; dealt <= dealt+1; flip and divide timers <= 0.
  - The other player's card is unchanged.
- RUN:
  - Flip timer increments each cycle; at FLIP_CYCLES-1 the next edge performs a flip.
  - Divide timer wraps at COUNT_DIV-1; on wrap, count decrements, saturating at 1 (never 0 while a card is showing).
  - If dealt==DECK_SIZE when the flip timer expires: no flip, state OVER, game_over=1.
- bell in RUN:
  - Next edge: state HOLD, hold=1.
  - count, cards and timers freeze.
  - bell and flip expiry in the same cycle: bell wins, no flip occurs.
- HOLD:
  - bell is ignored.
  - resume -> next edge: n1=n2=0, c1=c2=0, hold=0.
    - timers restart from 0; turn unchanged (the next flip goes to the other player).
    - state RUN if dealt<DECK_SIZE, else OVER with game_over=1.
  - count retains its frozen value until the next flip loads COUNT_INIT.
- OVER:
  - outputs hold; start -> performs the same clear as reset (except LFSR), then first flip; state RUN.
- bell/resume in IDLE or OVER: ignored. start in RUN/HOLD: ignored. Pulses are treated level-per-cycle; callers guarantee single-cycle pulses.
- LFSR advances every cycle in all states, so deal sequence depends on the start time.
- Reset asserted mid-game: immediate return to the reset values, regardless of state.

Decomposition:
- Shared package `inner_bell_pkg`:
  - state enum (IDLE, RUN, HOLD, OVER)
  - COLOR_W=2, NUM_W=3, SCORE_W=8
  - NUM_NONE=0, NUM_MAX=5
  - key codes KEY_P1=4'b0111, KEY_P2=4'b1001 (used upstream to form `bell`)
- Sub-module `card_lfsr`:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1.
  - Ports clk, rst, seed-on-reset; output 16-bit state.
- All other logic stays in card_dealer.

Test Plan (FLIP_CYCLES=4, COUNT_DIV=2, COUNT_INIT=10, DECK_SIZE=6):
- Reset then idle 20 cycles -> all outputs 0 except turn=1; no flip occurs without start.
- start -> next edge: turn=0, n1 in 1..5, n2=0, count=10, dealt=1.
  - count sequence 10,10,9,9 over the following cycles.
  - 4 cycles after the first flip: turn=1, n2 in 1..5, n1 unchanged, count=10, dealt=2.
- COUNT_DIV=2, FLIP_CYCLES=40 -> count decrements every 2 cycles down to 1 and holds at 1 until the next flip.
- bell coincident with flip-timer expiry -> hold=1, no flip, dealt unchanged, count frozen for 10 idle cycles.
  - Then resume -> n1=n2=0, hold=0, RUN; the next flip is 4 cycles later and goes to the player opposite `turn`.
- Run to 6 flips, let the timer expire -> game_over=1, state OVER, no 7th card.
  - bell ignored (hold stays 0); start -> dealt=1 and game restarts.
- Assert rst mid-HOLD -> outputs return to reset values asynchronously; a following resume is ignored.
